// File: rtl/sm_rf_wr_arbiter_if.sv
// sm_rf_wr_arbiter_if: core writeback, debug requester and register-file write port bundle.
interface sm_rf_wr_arbiter_if;
  logic        core_we;
  logic [4:0]  core_addr;
  logic [31:0] core_data;
  logic        core_stall;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic        dbg_pending;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  modport slave (
    input  core_we, core_addr, core_data, dbg_req, dbg_addr, dbg_data,
    output core_stall, dbg_ack, dbg_pending, rf_we, rf_a3, rf_wd3
  );
  modport master (
    output core_we, core_addr, core_data, dbg_req, dbg_addr, dbg_data,
    input  core_stall, dbg_ack, dbg_pending, rf_we, rf_a3, rf_wd3
  );
endinterface

// File: rtl/sm_rf_wr_arbiter.sv
// sm_rf_wr_arbiter: shares the register-file write port between core writeback and a debug writer.
module sm_rf_wr_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst_n,
  sm_rf_wr_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LAST = WW'(MAX_WAIT - 1);
  localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, FORCE = 2'd2;
  logic [1:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [4:0]    hold_addr;
  logic [31:0]   hold_data;
  logic          ack;
  logic          use_hold;
  assign use_hold        = state == FORCE || (state == PEND && !bus.core_we);
  assign bus.core_stall  = state == FORCE;
  assign bus.dbg_pending = state != IDLE;
  assign bus.dbg_ack     = ack;
  assign bus.rf_we       = use_hold ? hold_addr != 5'd0 : bus.core_we;
  assign bus.rf_a3       = use_hold ? hold_addr : bus.core_addr;
  assign bus.rf_wd3      = use_hold ? hold_data : bus.core_data;
  // ack follows exactly the cycle in which the held write owned the port
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      ack       <= 1'b0;
    end else begin
      ack <= use_hold;
      if (state == IDLE && bus.dbg_req && !ack) begin
        hold_addr <= bus.dbg_addr;
        hold_data <= bus.dbg_data;
        wait_cnt  <= '0;
        state     <= PEND;
      end else if (state == PEND && bus.core_we) begin
        wait_cnt <= wait_cnt == LAST ? '0 : wait_cnt + WW'(1);
        if (wait_cnt == LAST) state <= FORCE;
      end else if (use_hold) begin
        state <= IDLE;
      end
    end
endmodule
